// File: rtl/updown_ctrl_pkg.sv
// Shared encodings for the up/down counter sequencer: command opcodes and FSM states.
package updown_ctrl_pkg;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/updown_cnt_core.sv
// Up/down counter datapath with synchronous reset, parallel load and count enable.
module updown_cnt_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count
);

    // load takes priority over a step in the same cycle
    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (en)
            count <= dir ? count + WIDTH'(1) : count - WIDTH'(1);
    end

endmodule

// File: rtl/updown_cnt_ctrl.sv
// Command sequencer for the up/down counter: valid/ready commands, paced steps, done pulse.
// Optional saturation (suppress wrap, flag sat) is built when UDC_SAT_EN is defined.
module updown_cnt_ctrl
    import updown_ctrl_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 8,
    parameter int PACE   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [STEP_W-1:0] cmd_arg,
    input  logic              abort,
    output logic [WIDTH-1:0]  count,
    output logic              up_down,
    output logic              busy,
    output logic              done,
    output logic              sat
);

    localparam int PW = $clog2(PACE) + 1;
    localparam logic [PW-1:0] PACE_RELOAD = PW'(PACE - 1);

    state_t            state;
    logic [STEP_W-1:0] remaining;
    logic [PW-1:0]     pace_cnt;
    logic              xfer;
    logic              step_due;
    logic              step_en;
    logic              load_en;
    logic              sat_hit;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state == RUN);
    assign done      = (state == DONE);

    // abort suppresses a step that falls due in the same cycle
    always_comb begin
        xfer     = cmd_valid && cmd_ready;
        load_en  = xfer && (cmd_op == OP_LOAD);
        step_due = (state == RUN) && !abort && (pace_cnt == '0);
`ifdef UDC_SAT_EN
        sat_hit  = step_due && (up_down ? (count == '1) : (count == '0));
`else
        sat_hit  = 1'b0;
`endif
        step_en  = step_due && !sat_hit;
    end

`ifdef UDC_SAT_EN
    logic sat_r;
    assign sat = sat_r;
`else
    assign sat = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            remaining <= '0;
            pace_cnt  <= '0;
            up_down   <= 1'b1;
`ifdef UDC_SAT_EN
            sat_r     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        pace_cnt <= PACE_RELOAD;
`ifdef UDC_SAT_EN
                        sat_r    <= 1'b0;
`endif
                        if (cmd_op == OP_UP || cmd_op == OP_DOWN) begin
                            up_down   <= (cmd_op == OP_UP);
                            remaining <= cmd_arg;
                            state     <= (cmd_arg != '0) ? RUN : DONE;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= DONE;
                    end else if (step_due) begin
                        if (sat_hit) begin
                            state <= DONE;
`ifdef UDC_SAT_EN
                            sat_r <= 1'b1;
`endif
                        end else begin
                            pace_cnt  <= PACE_RELOAD;
                            remaining <= remaining - STEP_W'(1);
                            if (remaining == STEP_W'(1))
                                state <= DONE;
                        end
                    end else begin
                        pace_cnt <= pace_cnt - PW'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    updown_cnt_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .en       (step_en),
        .dir      (up_down),
        .load     (load_en),
        .load_val (cmd_arg[WIDTH-1:0]),
        .count    (count)
    );

endmodule

// File: tb/tb_updown_cnt_ctrl.sv
// Directed self-checking bench for updown_cnt_ctrl; one instance at PACE=1 and one at PACE=4.
module tb_updown_cnt_ctrl;

    localparam logic [1:0] NOP  = 2'b00;
    localparam logic [1:0] UP   = 2'b01;
    localparam logic [1:0] DOWN = 2'b10;
    localparam logic [1:0] LOAD = 2'b11;

    logic       clk = 1'b0;
    logic       reset = 1'b1;

    logic       cmd_valid = 1'b0, cmd_valid4 = 1'b0;
    logic [1:0] cmd_op = NOP, cmd_op4 = NOP;
    logic [7:0] cmd_arg = '0, cmd_arg4 = '0;
    logic       abort = 1'b0, abort4 = 1'b0;
    logic       cmd_ready, up_down, busy, done, sat;
    logic       cmd_ready4, up_down4, busy4, done4, sat4;
    logic [3:0] count, count4;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int base;

    always #5 clk = ~clk;

    always @(posedge clk) if (done) done_cnt++;

    updown_cnt_ctrl #(.WIDTH(4), .STEP_W(8), .PACE(1)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .abort(abort), .count(count),
        .up_down(up_down), .busy(busy), .done(done), .sat(sat)
    );

    updown_cnt_ctrl #(.WIDTH(4), .STEP_W(8), .PACE(4)) dut4 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid4), .cmd_ready(cmd_ready4),
        .cmd_op(cmd_op4), .cmd_arg(cmd_arg4), .abort(abort4), .count(count4),
        .up_down(up_down4), .busy(busy4), .done(done4), .sat(sat4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // returns just after the transfer edge
    task automatic send(input bit sel4, input logic [1:0] op, input logic [7:0] arg);
        if (sel4) begin
            cmd_valid4 = 1'b1; cmd_op4 = op; cmd_arg4 = arg;
        end else begin
            cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
        end
        tick();
        cmd_valid = 1'b0;
        cmd_valid4 = 1'b0;
    endtask

    initial begin
        // 1: reset state, UP 3
        tick(); tick();
        check("rst_count", count, 0);
        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_updown", up_down, 1);
        check("rst_sat", sat, 0);
        reset = 1'b0;
        tick();
        send(0, UP, 8'd3);
        check("up3_busy", busy, 1);
        check("up3_ready", cmd_ready, 0);
        check("up3_c0", count, 0);
        tick(); check("up3_c1", count, 1);
        tick(); check("up3_c2", count, 2);
        check("up3_nodone", done, 0);
        tick(); check("up3_c3", count, 3);
        check("up3_done", done, 1);
        check("up3_busy_end", busy, 0);
        tick(); check("up3_ready_after", cmd_ready, 1);
        check("up3_done_off", done, 0);

        // 2: LOAD E then UP 3 across the wrap point
        send(0, LOAD, 8'h0E);
        check("load_count", count, 4'hE);
        check("load_done", done, 1);
        check("load_updown_kept", up_down, 1);
        tick();
        send(0, UP, 8'd3);
        tick(); check("wrap_cF", count, 4'hF);
`ifdef UDC_SAT_EN
        tick(); check("sat_count", count, 4'hF);
        check("sat_done", done, 1);
        check("sat_flag", sat, 1);
`else
        tick(); check("wrap_c0", count, 0);
        check("wrap_nodone", done, 0);
        tick(); check("wrap_c1", count, 1);
        check("wrap_done", done, 1);
        check("wrap_sat", sat, 0);
`endif
        tick();

        // 4: UP 10, abort after the 2nd step
        send(0, LOAD, 8'd0);
`ifdef UDC_SAT_EN
        check("sat_clear", sat, 0);
`endif
        tick();
        base = done_cnt;
        send(0, UP, 8'd10);
        tick(); check("abort_c1", count, 1);
        tick(); check("abort_c2", count, 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_count", count, 2);
        check("abort_done", done, 1);
        tick();
        check("abort_count_hold", count, 2);
        check("abort_ready", cmd_ready, 1);
        tick();
        check("abort_one_pulse", done_cnt - base, 1);

        // 5: command held during RUN, then zero-length commands
        send(0, DOWN, 8'd2);
        cmd_valid = 1'b1; cmd_op = LOAD; cmd_arg = 8'h09;
        tick(); check("hold_c1", count, 1);
        tick(); check("hold_c0", count, 0);
        check("hold_done", done, 1);
        tick(); check("hold_idle_count", count, 0);
        check("hold_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        check("hold_loaded", count, 9);
        check("hold_load_done", done, 1);
        check("hold_updown_down", up_down, 0);
        tick();
        send(0, UP, 8'd0);
        check("up0_done", done, 1);
        check("up0_count", count, 9);
        check("up0_updown", up_down, 1);
        tick();
        send(0, NOP, 8'd5);
        check("nop_done", done, 1);
        check("nop_count", count, 9);
        check("nop_busy", busy, 0);
        tick();

        // 3: DOWN 5 at PACE=4 from 2
        send(1, LOAD, 8'd2);
        check("p4_load", count4, 2);
        tick();
        send(1, DOWN, 8'd5);
        for (int k = 1; k <= 20; k++) begin
            logic [3:0] e;
            e = 4'd2 - 4'(k / 4);
            tick();
            check($sformatf("p4_count_k%0d", k), count4, e);
            check($sformatf("p4_done_k%0d", k), done4, (k == 20) ? 1 : 0);
        end
        tick();
        check("p4_ready", cmd_ready4, 1);
        check("p4_updown", up_down4, 0);

        // 6: reset mid UP 8
        base = done_cnt;
        send(0, UP, 8'd8);
        tick(); tick(); tick();
        check("mid_count", count, 4'hC);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_count", count, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_ready", cmd_ready, 1);
        tick(); tick();
        check("mid_no_pulse", done_cnt - base, 0);
        send(0, UP, 8'd2);
        tick(); check("post_c1", count, 1);
        tick(); check("post_c2", count, 2);
        check("post_done", done, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
